// File: rtl/ccr_if.sv
// Bus between the execute stage and the condition-code / branch-resolution unit.
interface ccr_if;
    logic [2:0] alu_flag;
    logic       flag_we;
    logic       stall;
    logic [2:0] jmp_type;
    logic       int_ack;
    logic       rti;
    logic [2:0] ccr;
    logic       branch_taken;
    logic       flush;
    logic       int_busy;
    logic       shadow_valid;

    modport master (
        output alu_flag, flag_we, stall, jmp_type, int_ack, rti,
        input  ccr, branch_taken, flush, int_busy, shadow_valid
    );

    modport slave (
        input  alu_flag, flag_we, stall, jmp_type, int_ack, rti,
        output ccr, branch_taken, flush, int_busy, shadow_valid
    );
endinterface

// File: rtl/ccr_unit.sv
// Condition-code register with branch resolution and interrupt save/restore.
// A short freeze window after int_ack holds the CCR while the flag push completes.
module ccr_unit #(
    parameter int unsigned FREEZE_CYCLES = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    ccr_if.slave  bus
);

    localparam int unsigned CNT_W = 3;

    localparam logic [2:0] JMP_JZ  = 3'd1;
    localparam logic [2:0] JMP_JN  = 3'd2;
    localparam logic [2:0] JMP_JC  = 3'd3;
    localparam logic [2:0] JMP_JMP = 3'd4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_FREEZE = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ccr_q, ccr_d;
    logic [2:0]       shadow_q, shadow_d;
    logic             shadow_valid_q, shadow_valid_d;
    logic             cond_c;
    logic             taken_c;

    // Branch resolution against the registered CCR only
    always_comb begin
        cond_c = 1'b0;
        case (bus.jmp_type)
            JMP_JZ:  cond_c = ccr_q[0];
            JMP_JN:  cond_c = ccr_q[2];
            JMP_JC:  cond_c = ccr_q[1];
            JMP_JMP: cond_c = 1'b1;
            default: cond_c = 1'b0;
        endcase
        taken_c = rst_n & ~bus.stall & cond_c;
    end

    // Next-state and CCR/shadow update
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ccr_d          = ccr_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (!bus.stall) begin
                    if (bus.rti) begin
                        if (shadow_valid_q) begin
                            ccr_d          = shadow_q;
                            shadow_valid_d = 1'b0;
                        end
                    end else if (bus.flag_we) begin
                        ccr_d = bus.alu_flag;
                    end else if (taken_c) begin
                        case (bus.jmp_type)
                            JMP_JZ:  ccr_d[0] = 1'b0;
                            JMP_JN:  ccr_d[2] = 1'b0;
                            JMP_JC:  ccr_d[1] = 1'b0;
                            default: ccr_d    = ccr_q;
                        endcase
                    end
                    // Saves the pre-restore CCR when rti and int_ack coincide
                    if (bus.int_ack) begin
                        state_d        = ST_FREEZE;
                        shadow_d       = ccr_q;
                        shadow_valid_d = 1'b1;
                        cnt_d          = CNT_W'(FREEZE_CYCLES - 1);
                    end
                end
            end
            ST_FREEZE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            ccr_q          <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ccr_q          <= ccr_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end

    assign bus.ccr          = ccr_q;
    assign bus.branch_taken = taken_c;
    assign bus.flush        = taken_c;
    assign bus.int_busy     = (state_q == ST_FREEZE);
    assign bus.shadow_valid = shadow_valid_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Directed bench for ccr_unit: reset, branch resolve/clear, stall, freeze window, save/restore.
module tb_ccr_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ccr_if bus();

    ccr_unit #(.FREEZE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_flag = 3'b000;
        bus.flag_we  = 1'b0;
        bus.stall    = 1'b0;
        bus.jmp_type = 3'd0;
        bus.int_ack  = 1'b0;
        bus.rti      = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-cycle with a pending flag write
        bus.flag_we  = 1'b1;
        bus.alu_flag = 3'b111;
        tick();
        chk("pre_reset_ccr", bus.ccr, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ccr", bus.ccr, 3'b000);
        chk("rst_shadow_valid", {2'b00, bus.shadow_valid}, 3'b000);
        chk("rst_int_busy", {2'b00, bus.int_busy}, 3'b000);
        chk("rst_branch", {2'b00, bus.branch_taken}, 3'b000);
        idle_inputs();
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_reset_ccr", bus.ccr, 3'b000);

        // JZ taken then cleared; repeat not taken
        bus.flag_we  = 1'b1;
        bus.alu_flag = 3'b001;
        tick();
        chk("jz_setup_ccr", bus.ccr, 3'b001);
        bus.flag_we  = 1'b0;
        bus.jmp_type = 3'd1;
        settle();
        chk("jz_taken", {2'b00, bus.branch_taken}, 3'b001);
        chk("jz_flush", {2'b00, bus.flush}, 3'b001);
        tick();
        chk("jz_clear_ccr", bus.ccr, 3'b000);
        chk("jz_repeat_not_taken", {2'b00, bus.branch_taken}, 3'b000);
        tick();
        chk("jz_repeat_ccr", bus.ccr, 3'b000);

        // JC blocked by stall, then taken
        bus.jmp_type = 3'd0;
        bus.flag_we  = 1'b1;
        bus.alu_flag = 3'b110;
        tick();
        chk("jc_setup_ccr", bus.ccr, 3'b110);
        bus.flag_we  = 1'b0;
        bus.jmp_type = 3'd3;
        bus.stall    = 1'b1;
        settle();
        chk("jc_stall_not_taken", {2'b00, bus.branch_taken}, 3'b000);
        tick();
        chk("jc_stall_ccr", bus.ccr, 3'b110);
        bus.stall = 1'b0;
        settle();
        chk("jc_taken", {2'b00, bus.branch_taken}, 3'b001);
        tick();
        chk("jc_clear_ccr", bus.ccr, 3'b100);
        bus.jmp_type = 3'd0;

        // Interrupt freeze window with FREEZE_CYCLES=2
        bus.flag_we  = 1'b1;
        bus.alu_flag = 3'b101;
        tick();
        chk("int_setup_ccr", bus.ccr, 3'b101);
        bus.flag_we = 1'b0;
        bus.int_ack = 1'b1;
        settle();
        chk("int_busy_before", {2'b00, bus.int_busy}, 3'b000);
        tick();
        bus.int_ack = 1'b0;
        chk("int_busy_c1", {2'b00, bus.int_busy}, 3'b001);
        chk("int_shadow_valid", {2'b00, bus.shadow_valid}, 3'b001);
        bus.flag_we  = 1'b1;
        bus.alu_flag = 3'b010;
        tick();
        chk("int_busy_c2", {2'b00, bus.int_busy}, 3'b001);
        chk("freeze_ignore_write1", bus.ccr, 3'b101);
        tick();
        chk("int_busy_done", {2'b00, bus.int_busy}, 3'b000);
        chk("freeze_ignore_write2", bus.ccr, 3'b101);
        tick();
        chk("post_freeze_write", bus.ccr, 3'b010);
        bus.flag_we = 1'b0;

        // Restore from shadow, then a second rti is a no-op
        bus.rti = 1'b1;
        tick();
        chk("rti_restore_ccr", bus.ccr, 3'b101);
        chk("rti_shadow_invalid", {2'b00, bus.shadow_valid}, 3'b000);
        tick();
        chk("rti_second_ccr", bus.ccr, 3'b101);
        bus.rti = 1'b0;

        // Simultaneous rti and int_ack: shadow=101, ccr=010
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        tick();
        tick();
        chk("sim_setup_idle", {2'b00, bus.int_busy}, 3'b000);
        bus.flag_we  = 1'b1;
        bus.alu_flag = 3'b010;
        tick();
        chk("sim_setup_ccr", bus.ccr, 3'b010);
        bus.flag_we = 1'b0;
        bus.rti     = 1'b1;
        bus.int_ack = 1'b1;
        tick();
        bus.rti     = 1'b0;
        bus.int_ack = 1'b0;
        chk("sim_ccr", bus.ccr, 3'b101);
        chk("sim_shadow_valid", {2'b00, bus.shadow_valid}, 3'b001);
        chk("sim_int_busy", {2'b00, bus.int_busy}, 3'b001);
        tick();
        tick();
        bus.rti = 1'b1;
        tick();
        bus.rti = 1'b0;
        chk("sim_shadow_restore", bus.ccr, 3'b010);
        chk("sim_shadow_cleared", {2'b00, bus.shadow_valid}, 3'b000);

        // JMP taken without clearing, JN/reserved not taken
        bus.jmp_type = 3'd4;
        settle();
        chk("jmp_taken", {2'b00, bus.branch_taken}, 3'b001);
        tick();
        chk("jmp_no_clear", bus.ccr, 3'b010);
        bus.jmp_type = 3'd2;
        settle();
        chk("jn_not_taken", {2'b00, bus.branch_taken}, 3'b000);
        bus.jmp_type = 3'd6;
        settle();
        chk("reserved_not_taken", {2'b00, bus.flush}, 3'b000);

        // flag_we wins the update while the jump resolves on the old CCR
        bus.jmp_type = 3'd3;
        bus.flag_we  = 1'b1;
        bus.alu_flag = 3'b011;
        settle();
        chk("we_jc_taken_old", {2'b00, bus.branch_taken}, 3'b001);
        tick();
        chk("we_jc_ccr", bus.ccr, 3'b011);
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
